// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-port arbiter and fixed-latency sequencer for the shared memory bus.
// Decodes ROM/RAM windows; illegal accesses complete with err and no bus activity.
module mem_bus_arbiter #(
    parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
    parameter logic [31:0] RAM_BASE   = 32'h0002_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [63:0] wdata0,
    input  logic [63:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [63:0] rdata,
    output logic        busy,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] address,
    output logic [1:0]  size,
    inout  wire  [63:0] data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d, gnt_q, gnt_d, we_q, we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        win, win_we, hit_rom, hit_ram;
    logic [31:0] win_addr;

    always_comb begin
        // on a tie the port that did not win last time goes first
        win      = (req0 && req1) ? ~last_q : req1;
        win_we   = win ? we1 : we0;
        win_addr = win ? addr1 : addr0;
        hit_rom  = win_addr[31:ADDR_WIDTH] == ROM_BASE[31:ADDR_WIDTH];
        hit_ram  = win_addr[31:ADDR_WIDTH] == RAM_BASE[31:ADDR_WIDTH];
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                gnt_d   = win;
                last_d  = win;
                we_d    = win_we;
                addr_d  = win_addr;
                size_d  = win ? size1 : size0;
                wdata_d = win ? wdata1 : wdata0;
                cnt_d   = 3'd1;
                err_d   = !(hit_ram || (hit_rom && !win_we));
                state_d = err_d ? DONE : ACCESS;
            end
            ACCESS: if (cnt_q == LAT) begin
                state_d = DONE;
                rdata_d = we_q ? rdata_q : data;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack0     = state_q == DONE && !gnt_q;
    assign ack1     = state_q == DONE && gnt_q;
    assign err      = state_q == DONE && err_q;
    assign busy     = state_q != IDLE;
    assign memread  = state_q == ACCESS && !we_q;
    assign memwrite = state_q == ACCESS && we_q;
    assign address  = state_q == ACCESS ? addr_q : '0;
    assign size     = state_q == ACCESS ? size_q : '0;
    assign rdata    = rdata_q;
    assign data     = memwrite ? wdata_q : {64{1'bz}};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam logic [31:0] RAM_BASE = 32'h0002_0000;

    logic clock = 0, reset = 1, reset3 = 1;
    always #5 clock = ~clock;

    logic [1:0]  req_v = 2'b00;
    logic        t_we   [2];
    logic [31:0] t_addr [2];
    logic [1:0]  t_size [2];
    logic [63:0] t_w    [2];
    logic [31:0] salt = 32'h1357_9bdf;
    logic        ovr_en = 0;
    logic [63:0] ovr_val = '0;

    logic        ack0, ack1, err, busy, memread, memwrite;
    logic [63:0] rdata;
    logic [31:0] address;
    logic [1:0]  size;
    wire  [63:0] data;

    assign data = memread ? (ovr_en ? ovr_val : {address ^ salt, ~address}) : {64{1'bz}};

    mem_bus_arbiter #(.LATENCY(1)) u_dut (
        .clock(clock), .reset(reset), .req0(req_v[0]), .req1(req_v[1]),
        .we0(t_we[0]), .we1(t_we[1]), .addr0(t_addr[0]), .addr1(t_addr[1]),
        .size0(t_size[0]), .size1(t_size[1]), .wdata0(t_w[0]), .wdata1(t_w[1]),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
        .memread(memread), .memwrite(memwrite), .address(address), .size(size), .data(data)
    );

    logic        r3 = 0;
    logic [31:0] a3 = '0;
    logic        ack03, ack13, err3, busy3, memread3, memwrite3;
    logic [63:0] rdata3;
    logic [31:0] address3;
    logic [1:0]  size3;
    wire  [63:0] data3;

    assign data3 = memread3 ? {address3 ^ salt, ~address3} : {64{1'bz}};

    mem_bus_arbiter #(.LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset3), .req0(r3), .req1(1'b0),
        .we0(1'b0), .we1(1'b0), .addr0(a3), .addr1(32'h0),
        .size0(2'b01), .size1(2'b00), .wdata0(64'h1111_2222_3333_4444), .wdata1(64'h0),
        .ack0(ack03), .ack1(ack13), .err(err3), .rdata(rdata3), .busy(busy3),
        .memread(memread3), .memwrite(memwrite3), .address(address3), .size(size3), .data(data3)
    );

    int checks = 0, errors = 0;
    bit last_m = 1;
    logic [63:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic we, input logic [31:0] a);
        longint ua = longint'(a);
        return (ua >= longint'(RAM_BASE) && ua < longint'(RAM_BASE) + 1024) || (!we && ua < 1024);
    endfunction

    function automatic logic [63:0] exp_read(input logic [31:0] a);
        return ovr_en ? ovr_val : {a ^ salt, ~a};
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return RAM_BASE + 32'($urandom_range(0, 1023));
            1: return 32'($urandom_range(0, 1023));
            2: return RAM_BASE + 32'd1023;
            3: return RAM_BASE + 32'd1024;
            4: return 32'h0000_0400;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_port(input int p, input logic we, input logic [31:0] a, input logic [63:0] w);
        t_we[p]   = we;
        t_addr[p] = a;
        t_size[p] = 2'($urandom_range(0, 3));
        t_w[p]    = w;
    endtask

    // Called at a negedge with the DUT idle and the port's req already high.
    task automatic serve(input int p, input bit drop);
        int strobes = 0, n = 0;
        bit got = 0;
        bit ok = legal(t_we[p], t_addr[p]);
        if (ok && !t_we[p]) exp_rdata = exp_read(t_addr[p]);
        last_m = p[0];
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (memread || memwrite) begin
                strobes++;
                chk("bus_addr", address, t_addr[p]);
                chk("bus_size", size, t_size[p]);
                chk("bus_dir", {memwrite, memread}, t_we[p] ? 2'b10 : 2'b01);
                if (memwrite) chk("wbus", data, t_w[p]);
            end else begin
                chk("bus_quiet", data === t_w[p], 0);
            end
            got = ack0 || ack1;
        end
        chk("ack_seen", got, 1);
        chk("ack_port", {ack1, ack0}, p == 1 ? 2'b10 : 2'b01);
        chk("ack_cycle", n, ok ? 2 : 1);
        chk("err", err, !ok);
        chk("strobe_cycles", strobes, ok ? 1 : 0);
        chk("idle_addr", {size, address}, 0);
        chk("rdata", rdata, exp_rdata);
        if (drop) req_v[p] = 1'b0;
        @(negedge clock);
        chk("ack_pulse", {ack1, ack0, err, busy}, 0);
    endtask

    initial begin
        int mode, first, n, strobes;
        bit got;
        for (int p = 0; p < 2; p++) set_port(p, 0, RAM_BASE, 64'h0);
        #1;
        chk("rst_outs", {busy, memread, memwrite, ack0, ack1, err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus", {size, address}, 0);
        chk("rst3_outs", {busy3, memread3, memwrite3, ack03, err3}, 0);
        @(negedge clock);
        reset = 0;
        reset3 = 0;
        @(negedge clock);

        ovr_en = 1;
        ovr_val = 64'hDEAD_BEEF_0123_4567;
        set_port(0, 0, 32'h0002_0010, 64'h0F0F_0F0F_0F0F_0F0F);
        req_v[0] = 1;
        serve(0, 1);
        chk("tp_cpu_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
        ovr_en = 0;

        set_port(1, 1, 32'h0002_03FF, 64'hA5A5_A5A5_A5A5_A5A5);
        req_v[1] = 1;
        serve(1, 1);

        reset = 1;
        #1;
        chk("rst2_outs", {busy, ack0, ack1, err, memread, memwrite}, 0);
        chk("rst2_rdata", rdata, 0);
        reset = 0;
        last_m = 1;
        exp_rdata = '0;
        @(negedge clock);
        set_port(0, 0, RAM_BASE + 32'h40, 64'h1234_5678_9abc_def0);
        set_port(1, 0, RAM_BASE + 32'h80, 64'h0fed_cba9_8765_4321);
        req_v = 2'b11;
        serve(0, 0);
        serve(1, 0);
        serve(0, 0);
        serve(1, 1);
        req_v = 2'b00;

        set_port(0, 1, 32'h0000_0004, 64'h5555_aaaa_5555_aaaa);
        req_v[0] = 1;
        serve(0, 1);
        set_port(1, 0, 32'h0002_0400, 64'h7777_8888_9999_aaaa);
        req_v[1] = 1;
        serve(1, 1);
        set_port(0, 0, 32'h0000_03FF, 64'h0101_0101_0101_0101);
        req_v[0] = 1;
        serve(0, 1);
        set_port(0, 0, 32'h0000_0400, 64'h0202_0202_0202_0202);
        req_v[0] = 1;
        serve(0, 1);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            salt = $urandom;
            for (int p = 0; p < 2; p++) set_port(p, 1'($urandom_range(0, 1)), pick_addr(), {$urandom, $urandom} | 64'h1);
            if (mode == 2) begin
                req_v = 2'b11;
                first = last_m ? 0 : 1;
                serve(first, 1);
                serve(1 - first, 1);
            end else begin
                req_v[mode] = 1;
                serve(mode, 1);
            end
        end

        salt = 32'hc0de_f00d;
        a3 = 32'h0002_0020;
        r3 = 1;
        n = 0;
        strobes = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (memread3) strobes++;
            got = ack03;
        end
        chk("l3_strobes", strobes, 3);
        chk("l3_ack_cycle", n, 4);
        chk("l3_err", err3, 0);
        chk("l3_rdata", rdata3, {32'h0002_0020 ^ salt, ~32'h0002_0020});
        r3 = 0;
        @(negedge clock);
        chk("l3_ack_pulse", {ack03, busy3}, 0);

        a3 = 32'h0002_0030;
        r3 = 1;
        @(posedge clock);
        @(posedge clock);
        #2;
        chk("l3_mid_strobe", {memread3, address3}, {1'b1, 32'h0002_0030});
        reset3 = 1;
        r3 = 0;
        #1;
        chk("l3_rst_strobes", {memread3, memwrite3}, 0);
        chk("l3_rst_quiet", data3 === 64'h1111_2222_3333_4444, 0);
        chk("l3_rst_outs", {busy3, ack03, ack13, err3}, 0);
        chk("l3_rst_rdata", rdata3, 0);
        chk("l3_rst_bus", {size3, address3}, 0);
        @(negedge clock);
        reset3 = 0;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (ack03 || ack13 || busy3 || memread3) got = 1;
        end
        chk("l3_no_pending", got, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer for the shared 64-bit memory bus that connects the CPU datapath, the boot ROM and the data RAM. It accepts read/write requests from the CPU (port 0) and a DMA/loader engine (port 1), grants one at a time using round-robin, and decodes the address against the ROM and RAM windows. For a granted access it drives memread/memwrite, address, size and the bidirectional data bus for a fixed latency, captures read data, and returns a one-cycle acknowledge. Illegal accesses complete with an error and cause no bus activity.

## Interface
Parameters:
- ROM_BASE, 32'h00000000, ROM window base; the window spans 2^ADDR_WIDTH addresses.
- RAM_BASE, 32'h00020000, RAM window base; the window spans 2^ADDR_WIDTH addresses.
- ADDR_WIDTH, 10, window size exponent. A hit is address[31:ADDR_WIDTH] == BASE[31:ADDR_WIDTH].
- LATENCY, 1, bus cycles per access, legal range 1..7.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from CPU / DMA; held high until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  request address
- size0 / size1  in  2  access size, passed through unchanged
- wdata0 / wdata1  in  64  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err  out  1  valid with ack: the access was rejected
- rdata  out  64  read data, valid with ack on a successful read
- busy  out  1  state != IDLE
- memread / memwrite  out  1  bus strobes
- address  out  32  bus address
- size  out  2  bus size
- data  inout  64  driven with the latched wdata only while memwrite = 1, otherwise high-Z

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: bus access in progress; the cycle counter cnt runs from 1 to LATENCY.
  - DONE: completion cycle.
- IDLE, at least one req high:
  - Pick the winner. On a tie, grant the port that was not last_grant. last_grant resets to 1, so the CPU wins the first tie.
  - Latch the winner's addr, size, we and wdata, and record the winner as the granted port.
  - Update last_grant to the winner.
  - Decode: hit_rom, hit_ram.
  - Legal: hit_ram, or a read with hit_rom. Go to ACCESS with cnt = 1.
  - Illegal: no window hit, or a write with hit_rom. Go to DONE with err = 1. memread and memwrite stay 0.
- ACCESS:
  - memread = ~we_l, memwrite = we_l.
  - address and size come from the latched values.
  - If cnt == LATENCY: on the edge, capture data into rdata (reads only) and go to DONE. Otherwise cnt increments.
- DONE:
  - ack of the granted port is 1; err holds its value.
  - Strobes are 0 and data is high-Z.
  - The next state is always IDLE. Requests are not sampled in DONE, so a req still high in IDLE after the ack is treated as a new request.
- rdata holds its value until the next successful read. A write or an error leaves rdata unchanged.
- address and size outputs are 0 whenever not in ACCESS.

## Timing
- Legal access: req is sampled at edge E0.
  - Strobes are high from E0 through E_LATENCY.
  - rdata is captured at E_LATENCY.
  - ack is high from E_LATENCY to E_LATENCY+1.
  - Total LATENCY+2 cycles from req to IDLE.
- Illegal access: ack and err are high from E0 to E1; zero bus cycles.
- Back-to-back: with both req held continuously, the grant alternates 0,1,0,1. Each grant costs LATENCY+2 cycles.
- Reset (asynchronous, may occur mid-access). Immediately:
  - state = IDLE
  - memread = memwrite = 0
  - data high-Z
  - ack0 = ack1 = err = 0
  - rdata = 0, address = 0, size = 0
  - busy = 0, last_grant = 1
  - No pending access survives reset.
- Requester inputs may change after ack; the arbiter does not re-read them during ACCESS.
- size has no effect on decode.
- Window boundaries:
  - RAM_BASE + 2^ADDR_WIDTH - 1 hits RAM.
  - RAM_BASE + 2^ADDR_WIDTH misses, giving an error.

## Test plan
- CPU read at 0x00020010, LATENCY=1, with the RAM model returning 64'hDEADBEEF_01234567 → memread high one cycle, address 0x00020010, ack0 at E1-E2, rdata 64'hDEADBEEF_01234567, err 0.
- DMA write 64'hA5A5... to 0x000203FF → memwrite high one cycle, data bus carries 64'hA5A5... only during that cycle, ack1 pulse, err 0.
- req0 and req1 asserted together from reset and held → grant order 0,1,0,1. No overlap of strobes, and each ack is exactly one cycle.
- Write to 0x00000004 (ROM) and read of 0x00020400 (outside RAM) → ack with err = 1 at E0-E1, memread = memwrite = 0 throughout, rdata unchanged.
- LATENCY=3, CPU read → strobes high for 3 cycles, ack on the 4th cycle. Assert reset in cycle 2 → strobes drop and data is high-Z asynchronously, no ack, busy = 0, rdata = 0.
